// File: rtl/vend_pkg.sv
// Shared definitions for the vending machine coin-output path: coin encodings,
// denomination values and the change dispenser state machine encoding.
package vend_pkg;

    typedef enum logic [1:0] {
        COIN_NONE = 2'b00,
        COIN_1    = 2'b01,
        COIN_5    = 2'b10,
        COIN_10   = 2'b11
    } coin_t;

    localparam int DENOM_1  = 1;
    localparam int DENOM_5  = 5;
    localparam int DENOM_10 = 10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_PULSE  = 3'd2,
        ST_GAP    = 3'd3,
        ST_DONE   = 3'd4
    } disp_state_t;

    // Face value of a coin encoding; COIN_NONE is worth nothing.
    function automatic int denom_of(coin_t c);
        int v;
        v = 0;
        case (c)
            COIN_1:  v = DENOM_1;
            COIN_5:  v = DENOM_5;
            COIN_10: v = DENOM_10;
            default: v = 0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/coin_hopper.sv
// One hopper's inventory: a down-counter loaded with INIT on reset or refill,
// decremented once per dispensed coin, with an empty flag.
module coin_hopper
#(
    parameter int CNT_W = 6,
    parameter int INIT  = 8
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_count,
    output logic             o_empty
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(INIT);

    logic [CNT_W-1:0] r_count;

    // Decrement is gated by empty so the count can never wrap, even if the
    // caller misbehaves; the dispenser only selects non-empty hoppers anyway.
    always_ff @(posedge clk) begin
        if (reset || i_load) begin
            r_count <= LOAD_VAL;
        end else if (i_dec && !o_empty) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_count = r_count;
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/change_dispenser.sv
// Pays change out one coin at a time with greedy 10/5/1 selection, tracking
// hopper inventory and flagging a shortfall when exact change is impossible.
module change_dispenser
    import vend_pkg::*;
#(
    parameter int AMT_W    = 8,
    parameter int CNT_W    = 6,
    parameter int INIT_10  = 8,
    parameter int INIT_5   = 8,
    parameter int INIT_1   = 8,
    parameter int COIN_GAP = 2
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    input  logic [AMT_W-1:0] req_amount,
    output logic             req_ready,
    input  logic             refill,
    output logic             coin_out,
    output logic [1:0]       coin_type,
    output logic             done,
    output logic             short,
    output logic [AMT_W-1:0] remaining,
    output logic [CNT_W-1:0] inv_10,
    output logic [CNT_W-1:0] inv_5,
    output logic [CNT_W-1:0] inv_1,
    output disp_state_t      dbg_state
);

    // Handshake: a request transfers on a rising edge where req_valid and
    // req_ready are both high; req_ready is high exactly while IDLE, and
    // req_valid in any other state is ignored (nothing is queued).

    localparam int GAP_W = (COIN_GAP > 1) ? $clog2(COIN_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((COIN_GAP > 0) ? COIN_GAP - 1 : 0);
    localparam logic [AMT_W-1:0] AMT_10 = AMT_W'(DENOM_10);
    localparam logic [AMT_W-1:0] AMT_5  = AMT_W'(DENOM_5);
    localparam logic [AMT_W-1:0] AMT_1  = AMT_W'(DENOM_1);

    disp_state_t      r_state;
    disp_state_t      w_next;
    logic [AMT_W-1:0] r_rem;
    coin_t            r_coin;
    logic [GAP_W-1:0] r_gap_cnt;
    logic             r_short;
    logic [AMT_W-1:0] r_remaining;

    coin_t            w_sel;
    logic [AMT_W-1:0] w_denom;
    logic             w_refill_load;
    logic             w_dec_10;
    logic             w_dec_5;
    logic             w_dec_1;
    logic             w_empty_10;
    logic             w_empty_5;
    logic             w_empty_1;

    // Refill only counts in IDLE; a request in the same cycle sees new counts.
    assign w_refill_load = (r_state == ST_IDLE) && refill;
    assign w_dec_10      = (r_state == ST_PULSE) && (r_coin == COIN_10);
    assign w_dec_5       = (r_state == ST_PULSE) && (r_coin == COIN_5);
    assign w_dec_1       = (r_state == ST_PULSE) && (r_coin == COIN_1);

    coin_hopper #(.CNT_W(CNT_W), .INIT(INIT_10)) u_hopper_10 (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_refill_load),
        .i_dec   (w_dec_10),
        .o_count (inv_10),
        .o_empty (w_empty_10)
    );

    coin_hopper #(.CNT_W(CNT_W), .INIT(INIT_5)) u_hopper_5 (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_refill_load),
        .i_dec   (w_dec_5),
        .o_count (inv_5),
        .o_empty (w_empty_5)
    );

    coin_hopper #(.CNT_W(CNT_W), .INIT(INIT_1)) u_hopper_1 (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_refill_load),
        .i_dec   (w_dec_1),
        .o_count (inv_1),
        .o_empty (w_empty_1)
    );

    // Greedy pick falls through to a smaller coin when a hopper is empty.
    always_comb begin
        w_sel = COIN_NONE;
        if (r_rem >= AMT_10 && !w_empty_10) begin
            w_sel = COIN_10;
        end else if (r_rem >= AMT_5 && !w_empty_5) begin
            w_sel = COIN_5;
        end else if (r_rem >= AMT_1 && !w_empty_1) begin
            w_sel = COIN_1;
        end
    end

    always_comb begin
        w_denom = '0;
        case (r_coin)
            COIN_10: w_denom = AMT_10;
            COIN_5:  w_denom = AMT_5;
            COIN_1:  w_denom = AMT_1;
            default: w_denom = '0;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_next = (req_amount == '0) ? ST_DONE : ST_SELECT;
                end
            end
            ST_SELECT: w_next = (w_sel == COIN_NONE) ? ST_DONE : ST_PULSE;
            ST_PULSE:  w_next = (COIN_GAP == 0) ? ST_SELECT : ST_GAP;
            ST_GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_next = ST_SELECT;
                end
            end
            ST_DONE:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_rem       <= '0;
            r_coin      <= COIN_NONE;
            r_gap_cnt   <= '0;
            r_short     <= 1'b0;
            r_remaining <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_rem <= req_amount;
                    end
                end
                ST_SELECT: r_coin <= w_sel;
                ST_PULSE: begin
                    // Selection guaranteed r_rem >= w_denom, so no underflow.
                    r_rem     <= r_rem - w_denom;
                    r_gap_cnt <= '0;
                end
                ST_GAP:  r_gap_cnt <= r_gap_cnt + GAP_W'(1);
                default: ;
            endcase
            // Shortfall and remainder are captured as DONE is entered and held.
            if (w_next == ST_DONE) begin
                r_short     <= (r_state == ST_SELECT) && (r_rem != '0);
                r_remaining <= (r_state == ST_SELECT) ? r_rem : '0;
            end
        end
    end

    assign req_ready = (r_state == ST_IDLE);
    assign coin_out  = (r_state == ST_PULSE);
    assign coin_type = (r_state == ST_PULSE) ? r_coin : COIN_NONE;
    assign done      = (r_state == ST_DONE);
    assign short     = r_short;
    assign remaining = r_remaining;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser with default parameters (8/8/8, gap 2).
module tb_change_dispenser;
    import vend_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic [7:0]  req_amount = 8'd0;
    logic        req_ready;
    logic        refill = 1'b0;
    logic        coin_out;
    logic [1:0]  coin_type;
    logic        done;
    logic        short;
    logic [7:0]  remaining;
    logic [5:0]  inv_10, inv_5, inv_1;
    disp_state_t dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    logic [1:0] exp_q[$];
    int         exp_cyc_q[$];
    logic [1:0] got_type[$];
    int         got_cyc[$];
    int         done_k;
    logic       done_short;
    logic [7:0] done_rem;
    logic       ready_after;
    int         bad_type;

    always #5 clk = ~clk;

    change_dispenser #(
        .AMT_W(8), .CNT_W(6), .INIT_10(8), .INIT_5(8), .INIT_1(8), .COIN_GAP(2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_amount (req_amount),
        .req_ready  (req_ready),
        .refill     (refill),
        .coin_out   (coin_out),
        .coin_type  (coin_type),
        .done       (done),
        .short      (short),
        .remaining  (remaining),
        .inv_10     (inv_10),
        .inv_5      (inv_5),
        .inv_1      (inv_1),
        .dbg_state  (dbg_state)
    );

    // Issue one request and record coins / done relative to the handshake edge.
    // Cycle k is the k-th negedge after the handshake edge. While k < hold,
    // req_valid stays high with alt_amt to show a busy dispenser ignores it.
    task automatic do_req(input logic [7:0] amt, input logic with_refill,
                          input int hold, input logic [7:0] alt_amt);
        int w;
        got_type.delete();
        got_cyc.delete();
        done_k = -1;
        done_short = 1'b0;
        done_rem = 8'd0;
        ready_after = 1'b0;
        bad_type = 0;
        @(negedge clk);
        w = 0;
        while (!req_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!req_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL ready_wait got=%0b exp=1", req_ready);
        end
        req_valid  = 1'b1;
        req_amount = amt;
        refill     = with_refill;
        @(posedge clk);
        #1;
        refill     = 1'b0;
        req_amount = alt_amt;
        req_valid  = (hold > 0);
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (k >= hold) req_valid = 1'b0;
            if (done_k >= 0) begin
                ready_after = req_ready;
                break;
            end
            if (coin_out) begin
                got_type.push_back(coin_type);
                got_cyc.push_back(k);
            end else if (coin_type !== 2'b00) begin
                bad_type++;
            end
            if (done) begin
                done_k     = k;
                done_short = short;
                done_rem   = remaining;
            end
        end
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%0b exp=1", req_ready); end
        n_tests++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, ST_IDLE); end
        n_tests++; if (coin_out !== 1'b0 || coin_type !== 2'b00) begin n_fail++; $display("FAIL reset_coin got=%0b/%0b exp=0/00", coin_out, coin_type); end
        n_tests++; if (done !== 1'b0 || short !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%0b/%0b exp=0/0", done, short); end
        n_tests++; if (remaining !== 8'd0) begin n_fail++; $display("FAIL reset_remaining got=%0d exp=0", remaining); end
        n_tests++; if (inv_10 !== 6'd8 || inv_5 !== 6'd8 || inv_1 !== 6'd8) begin n_fail++; $display("FAIL reset_inv got=%0d/%0d/%0d exp=8/8/8", inv_10, inv_5, inv_1); end
    endtask

    task automatic test_greedy_16();
        exp_q = '{2'b11, 2'b10, 2'b01};
        exp_cyc_q = '{2, 6, 10};
        do_req(8'd16, 1'b0, 0, 8'd0);
        n_tests++; if (got_type.size() != exp_q.size()) begin n_fail++; $display("FAIL g16_count got=%0d exp=%0d", got_type.size(), exp_q.size()); end
        else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_tests++; if (got_type[i] !== exp_q[i] || got_cyc[i] != exp_cyc_q[i]) begin n_fail++; $display("FAIL g16_coin%0d got=%0b@%0d exp=%0b@%0d", i, got_type[i], got_cyc[i], exp_q[i], exp_cyc_q[i]); end
            end
        end
        n_tests++; if (done_k != 14 || done_short !== 1'b0 || done_rem !== 8'd0) begin n_fail++; $display("FAIL g16_done got=%0d/%0b/%0d exp=14/0/0", done_k, done_short, done_rem); end
        n_tests++; if (ready_after !== 1'b1) begin n_fail++; $display("FAIL g16_ready_after got=%0b exp=1", ready_after); end
        n_tests++; if (bad_type != 0) begin n_fail++; $display("FAIL g16_idle_type got=%0d exp=0", bad_type); end
        n_tests++; if (inv_10 !== 6'd7 || inv_5 !== 6'd7 || inv_1 !== 6'd7) begin n_fail++; $display("FAIL g16_inv got=%0d/%0d/%0d exp=7/7/7", inv_10, inv_5, inv_1); end
    endtask

    task automatic test_zero_amount();
        do_req(8'd0, 1'b0, 0, 8'd0);
        n_tests++; if (got_type.size() != 0) begin n_fail++; $display("FAIL zero_coins got=%0d exp=0", got_type.size()); end
        n_tests++; if (done_k != 1 || done_short !== 1'b0 || done_rem !== 8'd0) begin n_fail++; $display("FAIL zero_done got=%0d/%0b/%0d exp=1/0/0", done_k, done_short, done_rem); end
        n_tests++; if (ready_after !== 1'b1) begin n_fail++; $display("FAIL zero_ready_after got=%0b exp=1", ready_after); end
        n_tests++; if (inv_10 !== 6'd7 || inv_5 !== 6'd7 || inv_1 !== 6'd7) begin n_fail++; $display("FAIL zero_inv got=%0d/%0d/%0d exp=7/7/7", inv_10, inv_5, inv_1); end
    endtask

    task automatic test_fallthrough();
        // Standalone refill in IDLE, then empty the 10 hopper.
        @(negedge clk);
        refill = 1'b1;
        @(negedge clk);
        refill = 1'b0;
        n_tests++; if (inv_10 !== 6'd8 || inv_5 !== 6'd8 || inv_1 !== 6'd8) begin n_fail++; $display("FAIL refill_inv got=%0d/%0d/%0d exp=8/8/8", inv_10, inv_5, inv_1); end
        do_req(8'd80, 1'b0, 0, 8'd0);
        n_tests++; if (got_type.size() != 8 || done_k != 34 || inv_10 !== 6'd0) begin n_fail++; $display("FAIL drain10 got=%0d/%0d/%0d exp=8/34/0", got_type.size(), done_k, inv_10); end
        exp_q = '{2'b10, 2'b10, 2'b10, 2'b10};
        do_req(8'd20, 1'b0, 0, 8'd0);
        n_tests++; if (got_type.size() != exp_q.size()) begin n_fail++; $display("FAIL fall_count got=%0d exp=%0d", got_type.size(), exp_q.size()); end
        else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_tests++; if (got_type[i] !== exp_q[i]) begin n_fail++; $display("FAIL fall_coin%0d got=%0b exp=%0b", i, got_type[i], exp_q[i]); end
            end
        end
        n_tests++; if (done_k != 18 || done_short !== 1'b0 || done_rem !== 8'd0) begin n_fail++; $display("FAIL fall_done got=%0d/%0b/%0d exp=18/0/0", done_k, done_short, done_rem); end
        n_tests++; if (inv_10 !== 6'd0 || inv_5 !== 6'd4 || inv_1 !== 6'd8) begin n_fail++; $display("FAIL fall_inv got=%0d/%0d/%0d exp=0/4/8", inv_10, inv_5, inv_1); end
    endtask

    task automatic test_shortfall();
        do_req(8'd3, 1'b0, 0, 8'd0);
        do_req(8'd3, 1'b0, 0, 8'd0);
        n_tests++; if (inv_1 !== 6'd2 || done_short !== 1'b0) begin n_fail++; $display("FAIL drain1 got=%0d/%0b exp=2/0", inv_1, done_short); end
        do_req(8'd4, 1'b0, 0, 8'd0);
        n_tests++; if (got_type.size() != 2 || got_type[0] !== 2'b01 || got_type[1] !== 2'b01) begin n_fail++; $display("FAIL short_coins got=%0d exp=2", got_type.size()); end
        n_tests++; if (done_k != 10 || done_short !== 1'b1 || done_rem !== 8'd2) begin n_fail++; $display("FAIL short_done got=%0d/%0b/%0d exp=10/1/2", done_k, done_short, done_rem); end
        n_tests++; if (inv_1 !== 6'd0 || inv_5 !== 6'd4) begin n_fail++; $display("FAIL short_inv got=%0d/%0d exp=0/4", inv_1, inv_5); end
        n_tests++; if (short !== 1'b1 || remaining !== 8'd2) begin n_fail++; $display("FAIL short_held got=%0b/%0d exp=1/2", short, remaining); end
    endtask

    task automatic test_refill_with_request();
        do_req(8'd20, 1'b0, 0, 8'd0);
        n_tests++; if (inv_10 !== 6'd0 || inv_5 !== 6'd0 || inv_1 !== 6'd0) begin n_fail++; $display("FAIL drain_all got=%0d/%0d/%0d exp=0/0/0", inv_10, inv_5, inv_1); end
        do_req(8'd7, 1'b0, 0, 8'd0);
        n_tests++; if (got_type.size() != 0 || done_k != 2 || done_short !== 1'b1 || done_rem !== 8'd7) begin n_fail++; $display("FAIL empty_req got=%0d/%0d/%0b/%0d exp=0/2/1/7", got_type.size(), done_k, done_short, done_rem); end
        do_req(8'd10, 1'b1, 0, 8'd0);
        n_tests++; if (got_type.size() != 1 || got_type[0] !== 2'b11 || got_cyc[0] != 2) begin n_fail++; $display("FAIL refill_req_coin got=%0d exp=1 coin 11@2", got_type.size()); end
        n_tests++; if (done_k != 6 || done_short !== 1'b0 || done_rem !== 8'd0) begin n_fail++; $display("FAIL refill_req_done got=%0d/%0b/%0d exp=6/0/0", done_k, done_short, done_rem); end
        n_tests++; if (inv_10 !== 6'd7 || inv_5 !== 6'd8 || inv_1 !== 6'd8) begin n_fail++; $display("FAIL refill_req_inv got=%0d/%0d/%0d exp=7/8/8", inv_10, inv_5, inv_1); end
    endtask

    task automatic test_reset_mid_request();
        int coins;
        int late;
        coins = 0;
        late = 0;
        @(negedge clk);
        req_valid  = 1'b1;
        req_amount = 8'd30;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (coin_out) coins++;
        end
        // Cycle 7 is the first GAP cycle after the second coin.
        n_tests++; if (coins != 2 || dbg_state !== ST_GAP) begin n_fail++; $display("FAIL mid_pre got=%0d/%0d exp=2/%0d", coins, dbg_state, ST_GAP); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_tests++; if (req_ready !== 1'b1 || done !== 1'b0 || coin_out !== 1'b0) begin n_fail++; $display("FAIL mid_idle got=%0b/%0b/%0b exp=1/0/0", req_ready, done, coin_out); end
        n_tests++; if (inv_10 !== 6'd8 || inv_5 !== 6'd8 || inv_1 !== 6'd8) begin n_fail++; $display("FAIL mid_inv got=%0d/%0d/%0d exp=8/8/8", inv_10, inv_5, inv_1); end
        n_tests++; if (remaining !== 8'd0 || short !== 1'b0) begin n_fail++; $display("FAIL mid_outs got=%0d/%0b exp=0/0", remaining, short); end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (coin_out || done || !req_ready) late++;
        end
        n_tests++; if (late != 0) begin n_fail++; $display("FAIL mid_quiet got=%0d exp=0", late); end
    endtask

    task automatic test_busy_ignored();
        int late;
        late = 0;
        exp_q = '{2'b10, 2'b01};
        do_req(8'd6, 1'b0, 4, 8'd50);
        n_tests++; if (got_type.size() != exp_q.size()) begin n_fail++; $display("FAIL busy_count got=%0d exp=%0d", got_type.size(), exp_q.size()); end
        else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_tests++; if (got_type[i] !== exp_q[i]) begin n_fail++; $display("FAIL busy_coin%0d got=%0b exp=%0b", i, got_type[i], exp_q[i]); end
            end
        end
        n_tests++; if (done_k != 10 || done_short !== 1'b0) begin n_fail++; $display("FAIL busy_done got=%0d/%0b exp=10/0", done_k, done_short); end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (coin_out || done) late++;
        end
        n_tests++; if (late != 0) begin n_fail++; $display("FAIL busy_queued got=%0d exp=0", late); end
        n_tests++; if (inv_10 !== 6'd8 || inv_5 !== 6'd7 || inv_1 !== 6'd7) begin n_fail++; $display("FAIL busy_inv got=%0d/%0d/%0d exp=8/7/7", inv_10, inv_5, inv_1); end
    endtask

    task automatic test_back_to_back();
        do_req(8'd1, 1'b0, 0, 8'd0);
        n_tests++; if (done_k != 6 || ready_after !== 1'b1) begin n_fail++; $display("FAIL b2b_first got=%0d/%0b exp=6/1", done_k, ready_after); end
        do_req(8'd15, 1'b0, 0, 8'd0);
        n_tests++; if (got_type.size() != 2 || got_type[0] !== 2'b11 || got_type[1] !== 2'b10) begin n_fail++; $display("FAIL b2b_coins got=%0d exp=2", got_type.size()); end
        n_tests++; if (done_k != 10 || done_short !== 1'b0 || done_rem !== 8'd0) begin n_fail++; $display("FAIL b2b_done got=%0d/%0b/%0d exp=10/0/0", done_k, done_short, done_rem); end
        n_tests++; if (inv_10 !== 6'd7 || inv_5 !== 6'd6 || inv_1 !== 6'd6) begin n_fail++; $display("FAIL b2b_inv got=%0d/%0d/%0d exp=7/6/6", inv_10, inv_5, inv_1); end
    endtask

    initial begin
        test_reset();
        test_greedy_16();
        test_zero_amount();
        test_fallthrough();
        test_shortfall();
        test_refill_with_request();
        test_reset_mid_request();
        test_busy_ignored();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
